instr_fetch_arbiter: RTL and testbench

//  Shares the single synchronous instruction_rom read port between two fetch requesters (req0, req1).

---
 rtl/instr_fetch_arbiter_if.sv | 41 ++++
 rtl/instr_fetch_arbiter.sv | 102 ++++++++++
 tb/tb_instr_fetch_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_arbiter_if.sv
// Request/response channels of both fetch requesters plus the shared ROM read port.
// The slave modport is the arbiter's view; master is the fetch-unit/ROM side.
interface instr_fetch_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_addr;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_instr;
  logic             rsp0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_addr;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_instr;
  logic             rsp1_ready;

  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_instr;
  logic             busy;

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    input  req1_valid, req1_addr, rsp1_ready,
    input  rom_instr,
    output req0_ready, rsp0_valid, rsp0_instr,
    output req1_ready, rsp1_valid, rsp1_instr,
    output rom_addr, busy
  );

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    output req1_valid, req1_addr, rsp1_ready,
    output rom_instr,
    input  req0_ready, rsp0_valid, rsp0_instr,
    input  req1_ready, rsp1_valid, rsp1_instr,
    input  rom_addr, busy
  );
endinterface

// File: rtl/instr_fetch_arbiter.sv
// Round-robin share of the synchronous instruction ROM between two fetchers; accept -> response after 2 edges.
// One fetch in flight; requests stall in ADDR/RESP and a response is held until its requester is ready.
module instr_fetch_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  instr_fetch_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;

  logic             winner;
  logic             rdy0, rdy1;
  logic             vld0, vld1;
  logic [WIDTH-1:0] ins0, ins1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    vld0    = 1'b0;
    vld1    = 1'b0;
    ins0    = '0;
    ins1    = '0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          rdy0    = ~winner;
          rdy1    = winner;
          addr_d  = winner ? bus.req1_addr : bus.req0_addr;
          gnt_d   = winner;
          last_d  = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        state_d = RESP;
      end
      RESP: begin
        // rom_addr stays at addr_q, so rom_instr is stable while the response waits.
        if (gnt_q) begin
          vld1 = 1'b1;
          ins1 = bus.rom_instr;
          if (bus.rsp1_ready) state_d = IDLE;
        end else begin
          vld0 = 1'b1;
          ins0 = bus.rom_instr;
          if (bus.rsp0_ready) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Handshake outputs are quiet while Reset is held, whatever state is being abandoned.
  assign bus.req0_ready = rdy0 & ~Reset;
  assign bus.req1_ready = rdy1 & ~Reset;
  assign bus.rsp0_valid = vld0 & ~Reset;
  assign bus.rsp1_valid = vld1 & ~Reset;
  assign bus.rsp0_instr = Reset ? '0 : ins0;
  assign bus.rsp1_instr = Reset ? '0 : ins1;
  assign bus.rom_addr   = addr_q;
  assign bus.busy       = (state_q != IDLE) & ~Reset;

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Directed bench for instr_fetch_arbiter: a per-cycle vector table plus hand sequences for stalls,
// mid-transaction reset and streaming; a small synchronous ROM model supplies word_index+1.
module tb_instr_fetch_arbiter;

  logic CLK;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_fetch_arbiter_if #(.WIDTH(32)) ifc ();

  instr_fetch_arbiter #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (ifc.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    return (idx < 30'd16) ? {2'b00, idx} + 32'd1 : 32'd0;
  endfunction

  always @(posedge CLK) begin
    if (Reset) ifc.rom_instr <= 'x;
    else       ifc.rom_instr <= rom_word(ifc.rom_addr);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] rst, v0, a0, k0, v1, a1, k1;
    logic [31:0] rdy0, sv0, si0, rdy1, sv1, si1, busy, raddr;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic [31:0] rst, v0, a0, k0, v1, a1, k1,
                              input logic [31:0] rdy0, sv0, si0, rdy1, sv1, si1, busy, raddr);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.k0 = k0; v.v1 = v1; v.a1 = a1; v.k1 = k1;
    v.rdy0 = rdy0; v.sv0 = sv0; v.si0 = si0; v.rdy1 = rdy1; v.sv1 = sv1; v.si1 = si1;
    v.busy = busy; v.raddr = raddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setin(input logic v0, input logic [31:0] a0, input logic k0,
                       input logic v1, input logic [31:0] a1, input logic k1);
    ifc.req0_valid = v0; ifc.req0_addr = a0; ifc.rsp0_ready = k0;
    ifc.req1_valid = v1; ifc.req1_addr = a1; ifc.rsp1_ready = k1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".rdy0"}, 32'(ifc.req0_ready), 0);
    chk({nm, ".rdy1"}, 32'(ifc.req1_ready), 0);
    chk({nm, ".vld0"}, 32'(ifc.rsp0_valid), 0);
    chk({nm, ".vld1"}, 32'(ifc.rsp1_valid), 0);
    chk({nm, ".ins0"}, ifc.rsp0_instr, 0);
    chk({nm, ".ins1"}, ifc.rsp1_instr, 0);
    chk({nm, ".busy"}, 32'(ifc.busy), 0);
    chk({nm, ".raddr"}, ifc.rom_addr, 0);
  endtask

  initial begin
    int acc[4];
    int idx;
    int ridx;

    //            rst v0 a0    k0 v1 a1 k1 | rdy0 sv0 si0 rdy1 sv1 si1 busy raddr
    tbl[0]  = mk(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 4,    0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,    1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 4);
    tbl[3]  = mk(0, 0, 0,    1, 0, 0, 0,   0, 1, 2, 0, 0, 0, 1, 4);
    tbl[4]  = mk(0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 4);
    tbl[5]  = mk(1, 1, 0,    0, 1, 8, 0,   0, 0, 0, 0, 0, 0, 0, 4);
    tbl[6]  = mk(0, 1, 0,    0, 1, 8, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0,    1, 1, 8, 0,   0, 0, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0,    1, 1, 8, 0,   0, 1, 1, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0,    0, 1, 8, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,    0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 8);
    tbl[11] = mk(0, 0, 0,    0, 0, 0, 1,   0, 0, 0, 0, 1, 3, 1, 8);
    tbl[12] = mk(0, 1, 0,    0, 1, 8, 0,   1, 0, 0, 0, 0, 0, 0, 8);
    tbl[13] = mk(0, 0, 0,    1, 1, 8, 0,   0, 0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0,    1, 1, 8, 0,   0, 1, 1, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 1, 0,    0, 1, 8, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0,    0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1, 8);
    tbl[17] = mk(0, 1, 0,    0, 0, 0, 1,   0, 0, 0, 0, 1, 3, 1, 8);
    tbl[18] = mk(0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 8);
    tbl[19] = mk(0, 1, 'h40, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 8);
    tbl[20] = mk(0, 0, 0,    1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 'h40);
    tbl[21] = mk(0, 0, 0,    1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 'h40);
    tbl[22] = mk(0, 1, 5,    0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 'h40);
    tbl[23] = mk(0, 0, 0,    1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 5);
    tbl[24] = mk(0, 0, 0,    1, 0, 0, 0,   0, 1, 2, 0, 0, 0, 1, 5);
    tbl[25] = mk(0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 5);

    Reset = 1'b1;
    setin(0, 0, 0, 0, 0, 0);
    #1;
    step();
    step();

    for (int i = 0; i < 26; i++) begin
      Reset = tbl[i].rst[0];
      setin(tbl[i].v0[0], tbl[i].a0, tbl[i].k0[0], tbl[i].v1[0], tbl[i].a1, tbl[i].k1[0]);
      #1;
      chk($sformatf("row%0d.rdy0", i),  32'(ifc.req0_ready), tbl[i].rdy0);
      chk($sformatf("row%0d.vld0", i),  32'(ifc.rsp0_valid), tbl[i].sv0);
      chk($sformatf("row%0d.ins0", i),  ifc.rsp0_instr,      tbl[i].si0);
      chk($sformatf("row%0d.rdy1", i),  32'(ifc.req1_ready), tbl[i].rdy1);
      chk($sformatf("row%0d.vld1", i),  32'(ifc.rsp1_valid), tbl[i].sv1);
      chk($sformatf("row%0d.ins1", i),  ifc.rsp1_instr,      tbl[i].si1);
      chk($sformatf("row%0d.busy", i),  32'(ifc.busy),       tbl[i].busy);
      chk($sformatf("row%0d.raddr", i), ifc.rom_addr,        tbl[i].raddr);
      step();
    end
    Reset = 1'b0;

    // Response backpressure on requester 1 while requester 0 waits.
    setin(0, 0, 0, 1, 'hC, 0);
    #1;
    chk("bp.accept1", 32'(ifc.req1_ready), 1);
    step();
    setin(1, 0, 0, 0, 0, 0);
    #1;
    chk("bp.addr_rdy0", 32'(ifc.req0_ready), 0);
    chk("bp.addr_raddr", ifc.rom_addr, 'hC);
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp.hold%0d.vld1", c), 32'(ifc.rsp1_valid), 1);
      chk($sformatf("bp.hold%0d.ins1", c), ifc.rsp1_instr, 4);
      chk($sformatf("bp.hold%0d.rdy0", c), 32'(ifc.req0_ready), 0);
      chk($sformatf("bp.hold%0d.busy", c), 32'(ifc.busy), 1);
      step();
    end
    ifc.rsp1_ready = 1'b1;
    #1;
    chk("bp.done.vld1", 32'(ifc.rsp1_valid), 1);
    chk("bp.done.ins1", ifc.rsp1_instr, 4);
    step();
    ifc.rsp1_ready = 1'b0;
    #1;
    chk("bp.next.rdy0", 32'(ifc.req0_ready), 1);
    chk("bp.next.vld1", 32'(ifc.rsp1_valid), 0);
    step();
    setin(0, 0, 1, 0, 0, 0);
    step();
    #1;
    chk("bp.r0.vld0", 32'(ifc.rsp0_valid), 1);
    chk("bp.r0.ins0", ifc.rsp0_instr, 1);
    step();

    // Reset while in ADDR.
    setin(0, 0, 0, 1, 4, 0);
    #1;
    chk("rstaddr.accept1", 32'(ifc.req1_ready), 1);
    step();
    setin(0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    chk_quiet("rstaddr");
    step();
    #1;
    chk("rstaddr.stay_idle", 32'(ifc.busy), 0);

    // Reset while in RESP.
    setin(1, 8, 0, 0, 0, 0);
    #1;
    chk("rstresp.accept0", 32'(ifc.req0_ready), 1);
    step();
    setin(0, 0, 0, 0, 0, 0);
    step();
    #1;
    chk("rstresp.vld0", 32'(ifc.rsp0_valid), 1);
    chk("rstresp.ins0", ifc.rsp0_instr, 3);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    chk_quiet("rstresp");

    // A fresh requester-1 fetch after the aborted one.
    setin(0, 0, 0, 1, 'hC, 1);
    #1;
    chk("post.accept1", 32'(ifc.req1_ready), 1);
    step();
    ifc.req1_valid = 1'b0;
    step();
    #1;
    chk("post.vld1", 32'(ifc.rsp1_valid), 1);
    chk("post.ins1", ifc.rsp1_instr, 4);
    chk("post.vld0", 32'(ifc.rsp0_valid), 0);
    step();
    ifc.rsp1_ready = 1'b0;

    // Back-to-back stream from requester 0.
    idx  = 0;
    ridx = 0;
    for (int i = 0; i < 4; i++) acc[i] = -100;
    ifc.rsp0_ready = 1'b1;
    for (int c = 0; c < 40 && ridx < 4; c++) begin
      ifc.req0_valid = (idx < 4);
      ifc.req0_addr  = 32'(idx * 4);
      #1;
      if (ifc.req0_ready && idx < 4) begin
        acc[idx] = c;
        idx++;
      end
      if (ifc.rsp0_valid) begin
        chk($sformatf("b2b.ins%0d", ridx), ifc.rsp0_instr, 32'(ridx + 1));
        ridx++;
      end
      step();
    end
    ifc.req0_valid = 1'b0;
    ifc.rsp0_ready = 1'b0;
    chk("b2b.responses", 32'(ridx), 4);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("b2b.gap%0d", i), 32'(acc[i] - acc[i-1]), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
